// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD page scheduler: FSM states, page
// indices and the 16-bit field formatter used when building pages.
package lcd_sched_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, HOLD} state_t;

  localparam int unsigned PAGE_USER = 0;
  localparam int unsigned PAGE_DP   = 1;
  localparam int unsigned PAGE_MEM  = 2;
  localparam int unsigned PAGE_REG0 = 3;
  localparam int unsigned NBITS_LCD = 64;

  // Callers widen narrower signals with a 16'() size cast, which zero-extends.
  function automatic logic [15:0] f16(input logic [15:0] x);
    return x;
  endfunction

endpackage

// File: rtl/lcd_page_mux.sv
// Pure combinational formatter: turns a page index into the two 64-bit LCD
// lines (user lines, datapath, memory, or eight registers per page).
module lcd_page_mux
  import lcd_sched_pkg::*;
#(
  parameter int unsigned NBITS_TOP   = 8,
  parameter int unsigned NINSTR_BITS = 32,
  parameter int unsigned NREGS_TOP   = 32,
  parameter int unsigned NPAGES      = 3 + (NREGS_TOP + 7) / 8,
  parameter int unsigned PAGE_W      = $clog2(NPAGES)
) (
  input  logic [PAGE_W-1:0]      page,
  input  logic [NBITS_LCD-1:0]   user_a,
  input  logic [NBITS_LCD-1:0]   user_b,
  input  logic [NBITS_TOP-1:0]   dbg_pc,
  input  logic [NINSTR_BITS-1:0] dbg_instruction,
  input  logic [NBITS_TOP-1:0]   dbg_SrcA,
  input  logic [NBITS_TOP-1:0]   dbg_SrcB,
  input  logic [NBITS_TOP-1:0]   dbg_ALUResult,
  input  logic [NBITS_TOP-1:0]   dbg_Result,
  input  logic [NBITS_TOP-1:0]   dbg_WriteData,
  input  logic [NBITS_TOP-1:0]   dbg_ReadData,
  input  logic [NBITS_TOP-1:0]   dbg_regs [NREGS_TOP],
  input  logic                   dbg_MemWrite,
  input  logic                   dbg_Branch,
  input  logic                   dbg_MemtoReg,
  input  logic                   dbg_RegWrite,
  output logic [NBITS_LCD-1:0]   a,
  output logic [NBITS_LCD-1:0]   b
);

  localparam int unsigned NREG_PAD = 8 * (NPAGES - PAGE_REG0);
  localparam int unsigned IW       = $clog2(NREG_PAD);

  logic [15:0]   regs16 [NREG_PAD];
  logic [3:0]    flags;
  logic [IW-1:0] idx_a;
  logic [IW-1:0] idx_b;

  assign flags = {dbg_MemWrite, dbg_Branch, dbg_MemtoReg, dbg_RegWrite};

  // Register file padded to a whole number of pages; the tail reads as zero.
  always_comb begin
    regs16 = '{default: '0};
    for (int unsigned i = 0; i < NREGS_TOP; i++) begin
      regs16[i] = f16(16'(dbg_regs[i]));
    end
  end

  always_comb begin
    a     = '0;
    b     = '0;
    idx_a = '0;
    idx_b = '0;
    if (page == PAGE_W'(PAGE_USER)) begin
      a = user_a;
      b = user_b;
    end else if (page == PAGE_W'(PAGE_DP)) begin
      a = {32'(dbg_instruction), f16(16'(dbg_pc)), 12'h000, flags};
      b = {f16(16'(dbg_SrcA)), f16(16'(dbg_SrcB)),
           f16(16'(dbg_ALUResult)), f16(16'(dbg_Result))};
    end else if (page == PAGE_W'(PAGE_MEM)) begin
      a = {f16(16'(dbg_WriteData)), f16(16'(dbg_ReadData)), 32'h0000_0000};
    end else if (32'(page) < NPAGES) begin
      for (int unsigned j = 0; j < 4; j++) begin
        idx_a = IW'((32'(page) - PAGE_REG0) * 8 + j);
        idx_b = IW'((32'(page) - PAGE_REG0) * 8 + 4 + j);
        a[NBITS_LCD - 1 - 16 * j -: 16] = regs16[idx_a];
        b[NBITS_LCD - 1 - 16 * j -: 16] = regs16[idx_b];
      end
    end
  end

endmodule

// File: rtl/lcd_page_scheduler.sv
// Time-shares the 64-bit LCD driver between the user's lines and processor
// debug pages: capture one page per frame, hand it off via valid/ready, hold.
module lcd_page_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned NBITS_TOP      = 8,
  parameter int unsigned NINSTR_BITS    = 32,
  parameter int unsigned NREGS_TOP      = 32,
  parameter int unsigned REFRESH_CYCLES = 5000000,
  parameter int unsigned AUTO_FRAMES    = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   next_key,
  input  logic                   prev_key,
  input  logic                   auto_en,
  input  logic                   freeze,
  input  logic [63:0]            user_a,
  input  logic [63:0]            user_b,
  input  logic [NBITS_TOP-1:0]   dbg_pc,
  input  logic [NBITS_TOP-1:0]   dbg_SrcA,
  input  logic [NBITS_TOP-1:0]   dbg_SrcB,
  input  logic [NBITS_TOP-1:0]   dbg_ALUResult,
  input  logic [NBITS_TOP-1:0]   dbg_Result,
  input  logic [NBITS_TOP-1:0]   dbg_WriteData,
  input  logic [NBITS_TOP-1:0]   dbg_ReadData,
  input  logic [NINSTR_BITS-1:0] dbg_instruction,
  input  logic [NBITS_TOP-1:0]   dbg_regs [NREGS_TOP],
  input  logic                   dbg_MemWrite,
  input  logic                   dbg_Branch,
  input  logic                   dbg_MemtoReg,
  input  logic                   dbg_RegWrite,
  output logic [63:0]            lcd_a,
  output logic [63:0]            lcd_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(3 + (NREGS_TOP + 7) / 8)-1:0] cur_page
);

  localparam int unsigned NPAGES = 3 + (NREGS_TOP + 7) / 8;
  localparam int unsigned PAGE_W = $clog2(NPAGES);
  localparam int unsigned HCW    = $clog2(REFRESH_CYCLES);
  localparam int unsigned FCW    = $clog2(AUTO_FRAMES + 1);

  state_t             state;
  state_t             state_next;
  logic               next_q;
  logic               prev_q;
  logic               next_edge;
  logic               prev_edge;
  logic               key_step;
  logic               capture;
  logic               handshake;
  logic               hold_term;
  logic [HCW-1:0]     hold_cnt;
  logic [FCW-1:0]     frame_cnt;
  logic [FCW-1:0]     frame_next;
  int unsigned        frames_done;
  logic [PAGE_W-1:0]  page_next;
  logic [PAGE_W-1:0]  page_inc;
  logic [PAGE_W-1:0]  page_dec;
  logic [63:0]        frame_a;
  logic [63:0]        frame_b;

  lcd_page_mux #(
    .NBITS_TOP   (NBITS_TOP),
    .NINSTR_BITS (NINSTR_BITS),
    .NREGS_TOP   (NREGS_TOP),
    .NPAGES      (NPAGES),
    .PAGE_W      (PAGE_W)
  ) u_mux (
    .page            (cur_page),
    .user_a          (user_a),
    .user_b          (user_b),
    .dbg_pc          (dbg_pc),
    .dbg_instruction (dbg_instruction),
    .dbg_SrcA        (dbg_SrcA),
    .dbg_SrcB        (dbg_SrcB),
    .dbg_ALUResult   (dbg_ALUResult),
    .dbg_Result      (dbg_Result),
    .dbg_WriteData   (dbg_WriteData),
    .dbg_ReadData    (dbg_ReadData),
    .dbg_regs        (dbg_regs),
    .dbg_MemWrite    (dbg_MemWrite),
    .dbg_Branch      (dbg_Branch),
    .dbg_MemtoReg    (dbg_MemtoReg),
    .dbg_RegWrite    (dbg_RegWrite),
    .a               (frame_a),
    .b               (frame_b)
  );

  // Simultaneous next/prev edges cancel and count as no page change.
  assign next_edge = next_key & ~next_q;
  assign prev_edge = prev_key & ~prev_q;
  assign key_step  = next_edge ^ prev_edge;
  assign hold_term = (hold_cnt == HCW'(REFRESH_CYCLES - 1));
  assign page_inc  = (cur_page == PAGE_W'(NPAGES - 1)) ? '0 : cur_page + PAGE_W'(1);
  assign page_dec  = (cur_page == '0) ? PAGE_W'(NPAGES - 1) : cur_page - PAGE_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND:    if (out_ready) state_next = HOLD;
      HOLD:    if (key_step || (hold_term && !freeze)) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SEND);
    capture   = (state == CAPTURE);
    handshake = (state == SEND) && out_ready;
  end

  // Frame count saturates at AUTO_FRAMES while auto-scroll is off; a key step overrides auto.
  always_comb begin
    page_next   = cur_page;
    frame_next  = frame_cnt;
    frames_done = 32'(frame_cnt) + 1;
    if (handshake) begin
      if (auto_en && frames_done >= AUTO_FRAMES) begin
        page_next  = page_inc;
        frame_next = '0;
      end else begin
        frame_next = (frames_done > AUTO_FRAMES) ? FCW'(AUTO_FRAMES) : FCW'(frames_done);
      end
    end
    if (key_step) begin
      page_next  = next_edge ? page_inc : page_dec;
      frame_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      next_q    <= 1'b0;
      prev_q    <= 1'b0;
      cur_page  <= '0;
      frame_cnt <= '0;
      hold_cnt  <= '0;
      lcd_a     <= '0;
      lcd_b     <= '0;
    end else begin
      next_q    <= next_key;
      prev_q    <= prev_key;
      cur_page  <= page_next;
      frame_cnt <= frame_next;
      if (capture) begin
        lcd_a <= frame_a;
        lcd_b <= frame_b;
      end
      if (state != HOLD)   hold_cnt <= '0;
      else if (!hold_term) hold_cnt <= hold_cnt + HCW'(1);
    end
  end

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Bench for lcd_page_scheduler: a frame-timing model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_lcd_page_scheduler;

  localparam int unsigned NB = 8;
  localparam int unsigned NI = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned RC = 4;
  localparam int unsigned AF = 2;
  localparam int          NP = 7;

  logic        clk = 1'b0;
  logic        reset_n, next_key, prev_key, auto_en, freeze, out_ready;
  logic [63:0] user_a, user_b, lcd_a, lcd_b;
  logic [NB-1:0] dbg_pc, dbg_SrcA, dbg_SrcB, dbg_ALUResult, dbg_Result;
  logic [NB-1:0] dbg_WriteData, dbg_ReadData;
  logic [NI-1:0] dbg_instruction;
  logic [NB-1:0] dbg_regs [NR];
  logic        dbg_MemWrite, dbg_Branch, dbg_MemtoReg, dbg_RegWrite;
  logic        out_valid;
  logic [2:0]  cur_page;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lcd_page_scheduler #(
    .NBITS_TOP      (NB),
    .NINSTR_BITS    (NI),
    .NREGS_TOP      (NR),
    .REFRESH_CYCLES (RC),
    .AUTO_FRAMES    (AF)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .next_key        (next_key),
    .prev_key        (prev_key),
    .auto_en         (auto_en),
    .freeze          (freeze),
    .user_a          (user_a),
    .user_b          (user_b),
    .dbg_pc          (dbg_pc),
    .dbg_SrcA        (dbg_SrcA),
    .dbg_SrcB        (dbg_SrcB),
    .dbg_ALUResult   (dbg_ALUResult),
    .dbg_Result      (dbg_Result),
    .dbg_WriteData   (dbg_WriteData),
    .dbg_ReadData    (dbg_ReadData),
    .dbg_instruction (dbg_instruction),
    .dbg_regs        (dbg_regs),
    .dbg_MemWrite    (dbg_MemWrite),
    .dbg_Branch      (dbg_Branch),
    .dbg_MemtoReg    (dbg_MemtoReg),
    .dbg_RegWrite    (dbg_RegWrite),
    .lcd_a           (lcd_a),
    .lcd_b           (lcd_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .cur_page        (cur_page)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Page contents straight from the page map, built by shifting fields in.
  function automatic void content(input int p, output logic [63:0] a, output logic [63:0] b);
    logic [63:0] v;
    a = '0;
    b = '0;
    if (p == 0) begin
      a = user_a;
      b = user_b;
    end else if (p == 1) begin
      a = {dbg_instruction, 8'h00, dbg_pc, 12'h000,
           dbg_MemWrite, dbg_Branch, dbg_MemtoReg, dbg_RegWrite};
      b = {8'h00, dbg_SrcA, 8'h00, dbg_SrcB, 8'h00, dbg_ALUResult, 8'h00, dbg_Result};
    end else if (p == 2) begin
      a = {8'h00, dbg_WriteData, 8'h00, dbg_ReadData, 32'h0};
    end else begin
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = 8 * (p - 3) + j;
        v = (idx < int'(NR)) ? 64'(dbg_regs[idx]) : 64'h0;
        if (j < 4) a = (a << 16) | v;
        else       b = (b << 16) | v;
      end
    end
  endfunction

  // Model: m_wait counts clock edges until the next capture edge.
  int          m_page, m_wait, m_frames;
  bit          m_valid, m_idle, m_known, m_nq, m_pq;
  logic [63:0] m_a, m_b;

  initial m_known = 1'b0;

  always @(posedge clk) begin
    bit ne, pe, chg, done;
    if (!reset_n) begin
      m_known = 1'b1; m_page = 0; m_valid = 1'b0; m_a = '0; m_b = '0;
      m_frames = 0; m_nq = 1'b0; m_pq = 1'b0; m_wait = 2; m_idle = 1'b1;
    end else if (m_known) begin
      ne = next_key && !m_nq;
      pe = prev_key && !m_pq;
      m_nq = next_key;
      m_pq = prev_key;
      chg  = ne ^ pe;
      done = 1'b0;
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0; m_frames++; m_wait = RC + 1; done = 1'b1;
        end
      end else if (m_wait == 1) begin
        content(m_page, m_a, m_b);
        m_valid = 1'b1;
      end else if (chg) begin
        m_wait = 1;
      end else if (!(m_wait == 2 && freeze && !m_idle)) begin
        m_wait--;
      end
      m_idle = 1'b0;
      if (chg) begin
        m_page   = ne ? (m_page + 1) % NP : (m_page + NP - 1) % NP;
        m_frames = 0;
      end else if (done && auto_en && m_frames >= int'(AF)) begin
        m_page   = (m_page + 1) % NP;
        m_frames = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_out_valid", 64'(out_valid), 64'(m_valid));
      chk("model_cur_page", 64'(cur_page), 64'(m_page));
      chk("model_lcd_a", lcd_a, m_a);
      chk("model_lcd_b", lcd_b, m_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit is_next);
    if (is_next) next_key = 1'b1; else prev_key = 1'b1;
    tick(1);
    next_key = 1'b0;
    prev_key = 1'b0;
    tick(1);
  endtask

  task automatic next_frame();
    int n = 0;
    while (out_valid && n < 200) begin tick(1); n++; end
    while (!out_valid && n < 200) begin tick(1); n++; end
    chk("frame_within_budget", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_page(input int p, input string name);
    int n = 0;
    while (int'(cur_page) != p && n < 300) begin tick(1); n++; end
    chk(name, 64'(cur_page), 64'(p));
  endtask

  initial begin
    int rises;
    bit pv;
    reset_n = 1'b0; next_key = 1'b0; prev_key = 1'b0; auto_en = 1'b0;
    freeze = 1'b0; out_ready = 1'b1;
    user_a = 64'h0123_4567_89AB_CDEF;
    user_b = 64'hFEDC_BA98_7654_3210;
    dbg_pc = 8'h12; dbg_instruction = 32'h00A0_0093;
    dbg_SrcA = 8'd3; dbg_SrcB = 8'd4; dbg_ALUResult = 8'd7; dbg_Result = 8'd7;
    dbg_WriteData = 8'hAB; dbg_ReadData = 8'hCD;
    dbg_MemWrite = 1'b0; dbg_Branch = 1'b0; dbg_MemtoReg = 1'b0; dbg_RegWrite = 1'b1;
    for (int i = 0; i < int'(NR); i++) dbg_regs[i] = 8'(i);

    tick(3);
    chk("reset_lcd_a", lcd_a, 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    tick(1);
    chk("valid_after_1", 64'(out_valid), 64'd0);
    tick(1);
    chk("valid_after_2", 64'(out_valid), 64'd1);
    chk("user_a", lcd_a, 64'h0123_4567_89AB_CDEF);
    chk("user_b", lcd_b, 64'hFEDC_BA98_7654_3210);
    chk("page0", 64'(cur_page), 64'd0);

    pulse(1'b1);
    next_frame();
    chk("dp_a", lcd_a, 64'h00A0_0093_0012_0001);
    chk("dp_b", lcd_b, 64'h0003_0004_0007_0007);
    chk("dp_page", 64'(cur_page), 64'd1);

    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) next_key = 1'b1;
      if (i == 4) next_key = 1'b0;
      tick(1);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_a", lcd_a, 64'h00A0_0093_0012_0001);
      chk("stall_b", lcd_b, 64'h0003_0004_0007_0007);
    end
    chk("stall_page", 64'(cur_page), 64'd2);
    out_ready = 1'b1;
    next_frame();
    chk("mem_a", lcd_a, 64'h00AB_00CD_0000_0000);
    chk("mem_b", lcd_b, 64'h0);

    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b0);
    next_frame();
    next_frame();
    chk("wrap_prev_page", 64'(cur_page), 64'd6);
    chk("reg_a", lcd_a, 64'h0018_0019_001A_001B);
    chk("reg_b", lcd_b, 64'h001C_001D_001E_001F);

    auto_en = 1'b1;
    wait_page(0, "auto_wrap");
    next_key = 1'b1; prev_key = 1'b1;
    tick(1);
    next_key = 1'b0; prev_key = 1'b0;
    tick(1);
    chk("both_keys_page", 64'(cur_page), 64'd0);
    wait_page(1, "auto_step");
    auto_en = 1'b0;

    next_frame();
    freeze = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("freeze_quiet", 64'(out_valid), 64'd0);
    end
    rises = 0;
    pv = out_valid;
    next_key = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 0) next_key = 1'b0;
      if (out_valid && !pv) rises++;
      pv = out_valid;
    end
    chk("freeze_one_frame", 64'(rises), 64'd1);
    freeze = 1'b0;

    out_ready = 1'b0;
    next_frame();
    reset_n = 1'b0;
    tick(1);
    chk("reset_mid_send", 64'(out_valid), 64'd0);
    chk("reset_mid_send_page", 64'(cur_page), 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
